// File: rtl/lif_pkg.sv
// Shared types and constants for the leaky integrate-and-fire neuron.
// Holds the state encoding, guard-bit counts for the saturating datapath and a width helper.
package lif_pkg;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } lif_state_t;

  // Headroom above V_WIDTH so v - leak + S can never wrap before clamping.
  localparam int GUARD_BITS = 2;
  localparam int CNT_WIDTH  = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lif_neuron_if.sv
// Spike/weight inputs and neuron observation outputs bundled as one interface.
// No handshake: spike_in is sampled on every rising edge, weights are quasi-static.
interface lif_neuron_if #(
  parameter int NUM_IN  = 4,
  parameter int W_WIDTH = 4,
  parameter int V_WIDTH = 8
);
  import lif_pkg::*;

  logic [NUM_IN-1:0]         spike_in;
  logic [NUM_IN*W_WIDTH-1:0] weights;
  logic                      spike_out;
  logic [V_WIDTH-1:0]        membrane;
  logic                      refractory;
  lif_state_t                dbg_state;

  modport master (
    output spike_in, weights,
    input  spike_out, membrane, refractory, dbg_state
  );

  modport slave (
    input  spike_in, weights,
    output spike_out, membrane, refractory, dbg_state
  );

endinterface

// File: rtl/spike_weight_sum.sv
// Combinational gated adder: signed sum of the weights whose spike input is high.
// S_WIDTH is chosen by the parent wide enough that the sum cannot overflow.
module spike_weight_sum #(
  parameter int NUM_IN  = 4,
  parameter int W_WIDTH = 4,
  parameter int S_WIDTH = 10
) (
  input  logic [NUM_IN-1:0]         spike_in,
  input  logic [NUM_IN*W_WIDTH-1:0] weights,
  output logic signed [S_WIDTH-1:0] sum
);

  logic signed [W_WIDTH-1:0] w;

  always_comb begin
    sum = '0;
    w   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w = weights[i*W_WIDTH +: W_WIDTH];
      if (spike_in[i]) begin
        sum = sum + S_WIDTH'(w);
      end
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating membrane integration, threshold firing
// and a fixed-length refractory period, with the FSM state exposed for observation.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int W_WIDTH    = 4,
  parameter int V_WIDTH    = 8,
  parameter int THRESH     = 64,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 3
) (
  input logic   clk,
  input logic   reset,
  lif_neuron_if.slave bus
);

  localparam int SUM_W  = max_int(V_WIDTH + GUARD_BITS, W_WIDTH + $clog2(NUM_IN) + 1);
  localparam int CAND_W = max_int(V_WIDTH + GUARD_BITS, SUM_W) + 1;

  localparam logic signed [CAND_W-1:0] VMAX_EXT =
    $signed({{(CAND_W-V_WIDTH){1'b0}}, {V_WIDTH{1'b1}}});
  localparam logic [V_WIDTH-1:0]   THRESH_V = V_WIDTH'(THRESH);
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = (REFRAC > 0) ? CNT_WIDTH'(REFRAC - 1) : '0;

  lif_state_t             state_q, next_state;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [V_WIDTH-1:0]     v_q, v_d;
  logic                   spk_q, spk_d;

  logic signed [SUM_W-1:0]  syn_sum;
  logic [V_WIDTH-1:0]       leak;
  logic signed [CAND_W-1:0] v_ext, leak_ext, cand;
  logic [V_WIDTH-1:0]       v_clamped;

  spike_weight_sum #(
    .NUM_IN  (NUM_IN),
    .W_WIDTH (W_WIDTH),
    .S_WIDTH (SUM_W)
  ) u_sum (
    .spike_in (bus.spike_in),
    .weights  (bus.weights),
    .sum      (syn_sum)
  );

  assign leak     = v_q >> LEAK_SHIFT;
  assign v_ext    = $signed({{(CAND_W-V_WIDTH){1'b0}}, v_q});
  assign leak_ext = $signed({{(CAND_W-V_WIDTH){1'b0}}, leak});
  assign cand     = v_ext - leak_ext + CAND_W'(syn_sum);

  always_comb begin
    v_clamped = cand[V_WIDTH-1:0];
    if (cand < 0) begin
      v_clamped = '0;
    end else if (cand > VMAX_EXT) begin
      v_clamped = '1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INTEGRATE;
      cnt_q   <= '0;
      v_q     <= '0;
      spk_q   <= 1'b0;
    end else begin
      state_q <= next_state;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      spk_q   <= spk_d;
    end
  end

  // The counter is loaded with REFRAC-1 so that REFRACTORY spans exactly REFRAC edges.
  always_comb begin
    next_state = state_q;
    cnt_d      = cnt_q;
    v_d        = v_q;
    spk_d      = 1'b0;
    case (state_q)
      INTEGRATE: begin
        if (v_clamped >= THRESH_V) begin
          spk_d = 1'b1;
          v_d   = '0;
          if (REFRAC > 0) begin
            next_state = REFRACTORY;
            cnt_d      = CNT_INIT;
          end
        end else begin
          v_d = v_clamped;
        end
      end
      REFRACTORY: begin
        v_d = '0;
        if (cnt_q == '0) begin
          next_state = INTEGRATE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        next_state = INTEGRATE;
        cnt_d      = '0;
        v_d        = '0;
      end
    endcase
  end

  assign bus.spike_out  = spk_q;
  assign bus.membrane   = v_q;
  assign bus.refractory = (state_q == REFRACTORY);
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: a default-parameter instance plus a REFRAC=0, THRESH=10
// instance, checked with immediate assertions against hand-computed membrane traces.
module tb_lif_neuron;
  import lif_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  lif_neuron_if #(.NUM_IN(4), .W_WIDTH(4), .V_WIDTH(8)) bus_a ();
  lif_neuron_if #(.NUM_IN(4), .W_WIDTH(4), .V_WIDTH(8)) bus_b ();

  lif_neuron dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  lif_neuron #(.THRESH(10), .REFRAC(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_a(input string tag, input logic [7:0] mem, input logic spk, input logic refr);
    check({tag, "_mem"}, 32'(bus_a.membrane), 32'(mem));
    check({tag, "_spk"}, 32'(bus_a.spike_out), 32'(spk));
    check({tag, "_refr"}, 32'(bus_a.refractory), 32'(refr));
  endtask

  initial begin
    int leak_seq[6];
    logic spiked;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_a.spike_in = '0;
    bus_a.weights  = '0;
    bus_b.spike_in = '0;
    bus_b.weights  = '0;
    step();
    step();
    check_a("reset_a", 8'd0, 1'b0, 1'b0);
    check("reset_a_state", 32'(bus_a.dbg_state), 32'(INTEGRATE));
    check("reset_b_mem", 32'(bus_b.membrane), 32'd0);
    reset = 1'b0;

    // All four synapses +7: 28, 53, fire, three refractory edges, then 28 again.
    bus_a.weights  = {4'h7, 4'h7, 4'h7, 4'h7};
    bus_a.spike_in = 4'b1111;
    step(); check_a("fire_e1", 8'd28, 1'b0, 1'b0);
    step(); check_a("fire_e2", 8'd53, 1'b0, 1'b0);
    step(); check_a("fire_e3", 8'd0, 1'b1, 1'b1);
    step(); check_a("refr_e1", 8'd0, 1'b0, 1'b1);
    step(); check_a("refr_e2", 8'd0, 1'b0, 1'b1);
    step(); check_a("refr_e3", 8'd0, 1'b0, 1'b0);
    check("refr_e3_state", 32'(bus_a.dbg_state), 32'(INTEGRATE));
    step(); check_a("resume", 8'd28, 1'b0, 1'b0);
    step(); check_a("resume2", 8'd53, 1'b0, 1'b0);
    step(); check_a("refire", 8'd0, 1'b1, 1'b1);

    // Asynchronous reset while REFRACTORY: outputs clear before any edge.
    #2 reset = 1'b1;
    #1;
    check_a("async_rst", 8'd0, 1'b0, 1'b0);
    check("async_rst_state", 32'(bus_a.dbg_state), 32'(INTEGRATE));
    bus_a.spike_in = 4'b0000;
    step();
    reset = 1'b0;
    step(); check_a("post_rst", 8'd0, 1'b0, 1'b0);
    check("post_rst_state", 32'(bus_a.dbg_state), 32'(INTEGRATE));

    // Mixed signs +7,-8,+7,+7 give S=+13.
    bus_a.weights  = {4'h7, 4'h7, 4'h8, 4'h7};
    bus_a.spike_in = 4'b1111;
    step(); check_a("mixed_e1", 8'd13, 1'b0, 1'b0);
    step(); check_a("mixed_e2", 8'd25, 1'b0, 1'b0);
    step(); check_a("mixed_e3", 8'd35, 1'b0, 1'b0);

    // Underflow clamps at zero rather than wrapping.
    bus_a.spike_in = 4'b0000;
    do_reset();
    bus_a.weights  = {4'h0, 4'h0, 4'h0, 4'h5};
    bus_a.spike_in = 4'b0001;
    step(); check_a("clamp_pre", 8'd5, 1'b0, 1'b0);
    bus_a.weights  = {4'h0, 4'h0, 4'h0, 4'h8};
    step(); check_a("clamp_lo1", 8'd0, 1'b0, 1'b0);
    step(); check_a("clamp_lo2", 8'd0, 1'b0, 1'b0);

    // Single +7 synapse: leak balances input below threshold.
    bus_a.spike_in = 4'b0000;
    do_reset();
    leak_seq = '{7, 14, 20, 25, 29, 33};
    bus_a.weights  = {4'h0, 4'h0, 4'h0, 4'h7};
    bus_a.spike_in = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("leak_e%0d", i + 1), 32'(bus_a.membrane), 32'(leak_seq[i]));
    end
    spiked = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      spiked = spiked | bus_a.spike_out;
    end
    check("leak_no_spike", 32'(spiked), 32'd0);
    check("leak_conv_lo", 32'(bus_a.membrane >= 8'd56), 32'd1);
    check("leak_conv_hi", 32'(bus_a.membrane <= 8'd63), 32'd1);
    check("leak_conv_val", 32'(bus_a.membrane), 32'd56);

    // REFRAC=0 instance fires on every edge with S=14 >= 10.
    bus_b.weights  = {4'h0, 4'h0, 4'h7, 4'h7};
    bus_b.spike_in = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("b2b_spk%0d", i), 32'(bus_b.spike_out), 32'd1);
      check($sformatf("b2b_mem%0d", i), 32'(bus_b.membrane), 32'd0);
      check($sformatf("b2b_refr%0d", i), 32'(bus_b.refractory), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lif_neuron.md
LIF_NEURON -- requirements
Module: lif_neuron

Interface
REQ-001 Parameter NUM_IN, default 4: number of spike inputs (synapses).
REQ-002 Parameter W_WIDTH, default 4: width of each signed two's-complement synaptic weight.
REQ-003 Parameter V_WIDTH, default 8: width of the unsigned membrane potential.
REQ-004 Parameter THRESH, default 64: firing threshold, 1..2^V_WIDTH-1.
REQ-005 Parameter LEAK_SHIFT, default 3: leak term is v >> LEAK_SHIFT per integrate cycle.
REQ-006 Parameter REFRAC, default 3: refractory length in cycles, 0..15.
REQ-007 clk  input  1  clock; all state updates on the rising edge.
REQ-008 reset  input  1  reset; asynchronous, active-high.
REQ-009 spike_in  input  NUM_IN  one-cycle spike pulses from upstream rate encoders, sampled every edge.
REQ-010 weights  input  NUM_IN*W_WIDTH  packed signed weights; weight i = bits [i*W_WIDTH +: W_WIDTH]; quasi-static.
REQ-011 spike_out  output  1  registered one-cycle output spike.
REQ-012 membrane  output  V_WIDTH  registered membrane potential v.
REQ-013 refractory  output  1  high while the neuron is in REFRACTORY.

Function
REQ-014 States: INTEGRATE, REFRACTORY; reset state INTEGRATE.
REQ-015 Synaptic sum S = signed sum of weight i over all i with spike_in[i]=1; no spikes -> S = 0.
REQ-016 S, leak and candidate computed at signed width V_WIDTH+2 minimum; no intermediate overflow.
REQ-017 In INTEGRATE, candidate c = v - (v >> LEAK_SHIFT) + S.
REQ-018 c < 0 -> clamp to 0; c > 2^V_WIDTH-1 -> clamp to 2^V_WIDTH-1.
REQ-019 Clamped c >= THRESH at an edge -> same edge: spike_out<=1, v<=0; REFRAC>0 -> state<=REFRACTORY and counter<=REFRAC-1; REFRAC=0 -> stay INTEGRATE.
REQ-020 Otherwise in INTEGRATE: v<=clamped c, spike_out<=0.
REQ-021 Latency: spike_in sampled at edge n is reflected in membrane/spike_out after edge n; no further pipeline delay.
REQ-022 In REFRACTORY: spike_in ignored, v held at 0, no leak, spike_out<=0; counter decrements each edge; at counter==0 state<=INTEGRATE.
REQ-023 REFRACTORY therefore lasts exactly REFRAC edges; integration resumes on the next edge.
REQ-024 spike_out never high two consecutive cycles when REFRAC>0; with REFRAC=0, back-to-back spikes allowed.
REQ-025 refractory = (state == REFRACTORY), registered.

Reset
REQ-026 reset asserted -> immediately: spike_out=0, membrane=0, refractory=0, state=INTEGRATE, counter=0, regardless of the current state.
REQ-027 First integration uses spike_in sampled on the first rising edge after reset deasserts.

Structure
REQ-028 Package lif_pkg holds the state enum (INTEGRATE, REFRACTORY) and the clamp/saturation helper constants.
REQ-029 Sub-module spike_weight_sum: combinational gated signed adder (spike_in, weights -> S), parameterised NUM_IN and W_WIDTH.
REQ-030 lif_neuron holds the state machine, refractory counter, membrane register and output register.

Verification (defaults unless stated)
REQ-031 Reset mid-REFRACTORY -> all outputs 0 immediately; one edge after release with spike_in=0 -> membrane stays 0, state INTEGRATE.
REQ-032 spike_in=4'b0001, weight0=+7 held constant -> membrane 7,14,20,25,29,33,... converges within 56..63; spike_out never asserted.
REQ-033 spike_in=4'b1111, all weights +7 -> membrane 28, 53, then spike_out=1 and membrane=0 on 3rd edge; refractory=1 for next 3 edges with membrane 0; 4th edge after spike -> membrane 28.
REQ-034 membrane=5, spike_in=4'b0001, weight0=-8 -> membrane clamps to 0, never wraps.
REQ-035 REFRAC=0, THRESH=10, spike_in=4'b0011, weights +7,+7 -> spike_out=1 every edge, membrane 0 each cycle.
REQ-036 Mixed signs weights +7,-8,+7,+7, spike_in=4'b1111 -> S=+13; membrane 13, 25, 35 on first three edges.
